// File: rtl/stack_op_sequencer.sv
// Stack-operation sequencer: owns SP and runs one memory-stack bus cycle per op (two for INTR).
// Optional feature macro STACK_SEQ_IRQ_EN: irq in IDLE starts an INTR ahead of req.
module stack_op_sequencer #(
  parameter logic [7:0] SP_TOP    = 8'd255,
  parameter logic [7:0] SP_BOTTOM = 8'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] op,
  output logic       ready,
  input  logic [7:0] pc_in,
  input  logic [3:0] ccr_in,
  input  logic [7:0] wdata_in,
  input  logic       irq,
  output logic       mem_en,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] stack_ctrl,
  output logic       stack_push,
  output logic       stack_pop,
  output logic [7:0] wdata,
  input  logic [7:0] mem_rdata,
  input  logic [3:0] ccr_rd,
  output logic [7:0] sp,
  output logic       done,
  output logic [7:0] rdata,
  output logic [3:0] ccr_out,
  output logic       err
);
  // state | meaning
  // IDLE  | ready, waiting for req (or irq)
  // BUS1  | first bus cycle, or no-bus cycle on fault
  // BUS2  | INTR flags write
  // DONE  | done/err pulse
  typedef enum logic [1:0] {IDLE, BUS1, BUS2, DONE} state_t;

  localparam logic [2:0] OP_PUSH = 3'd0, OP_POP = 3'd1, OP_CALL = 3'd2,
                         OP_RET  = 3'd3, OP_RTI = 3'd4, OP_INTR = 3'd5;

  state_t     r_state;
  logic [2:0] r_op;
  logic [3:0] r_ccr;
  logic       r_fault;
  logic [7:0] r_sp, r_rdata, r_wdata;
  logic [3:0] r_ccr_out, r_stack_ctrl;
  logic       r_done, r_err, r_mem_en, r_mem_read, r_mem_write, r_push, r_pop;

  logic       w_irq_take, w_accept, w_push_t, w_pop_t, w_fault;
  logic [2:0] w_op;

`ifdef STACK_SEQ_IRQ_EN
  assign w_irq_take = irq && (r_state == IDLE);
`else
  logic w_unused_irq;
  assign w_unused_irq = irq;
  assign w_irq_take   = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && (w_irq_take || req);
  assign w_op     = w_irq_take ? OP_INTR : op;
  assign w_push_t = (w_op == OP_PUSH) || (w_op == OP_CALL) || (w_op == OP_INTR);
  assign w_pop_t  = (w_op == OP_POP) || (w_op == OP_RET) || (w_op == OP_RTI);
  assign w_fault  = !(w_push_t || w_pop_t) || (w_push_t && r_sp == SP_BOTTOM)
                    || (w_pop_t && r_sp == SP_TOP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_op         <= OP_PUSH;
      r_ccr        <= 4'h0;
      r_fault      <= 1'b0;
      r_sp         <= SP_TOP;
      r_rdata      <= 8'h00;
      r_wdata      <= 8'h00;
      r_ccr_out    <= 4'h0;
      r_stack_ctrl <= 4'h0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_push       <= 1'b0;
      r_pop        <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_push       <= 1'b0;
      r_pop        <= 1'b0;
      r_stack_ctrl <= 4'h0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= w_op;
          r_ccr   <= ccr_in;
          r_fault <= w_fault;
          r_state <= BUS1;
          // bus strobes are registered, so BUS1's cycle is set up here
          if (!w_fault) begin
            r_mem_en     <= 1'b1;
            r_stack_ctrl <= {1'b0, w_op} + 4'd1;
            if (w_push_t) begin
              r_mem_write <= 1'b1;
              r_push      <= 1'b1;
              r_wdata     <= (w_op == OP_PUSH) ? wdata_in : pc_in;
            end else begin
              r_mem_read <= 1'b1;
              r_pop      <= 1'b1;
            end
          end
        end
        BUS1: begin
          r_state <= DONE;
          if (r_fault) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
            if (r_op == OP_POP || r_op == OP_RET || r_op == OP_RTI) r_rdata <= 8'h00;
          end else if (r_mem_write) begin
            r_sp <= r_sp - 8'd1;
            if (r_op == OP_INTR) begin
              r_state      <= BUS2;
              r_mem_en     <= 1'b1;
              r_mem_write  <= 1'b1;
              r_stack_ctrl <= 4'b0111;
              r_wdata      <= {4'h0, r_ccr};
            end else begin
              r_done <= 1'b1;
            end
          end else begin
            r_rdata <= mem_rdata;
            r_sp    <= r_sp + 8'd1;
            if (r_op == OP_RTI) r_ccr_out <= ccr_rd;
            r_done  <= 1'b1;
          end
        end
        BUS2: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready      = (r_state == IDLE) && !w_irq_take;
  assign mem_en     = r_mem_en;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign stack_ctrl = r_stack_ctrl;
  assign stack_push = r_push;
  assign stack_pop  = r_pop;
  assign wdata      = r_wdata;
  assign sp         = r_sp;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign ccr_out    = r_ccr_out;
  assign err        = r_err;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer; inputs driven and outputs sampled on negedge.
module tb_stack_op_sequencer;
  logic       clk = 1'b0;
  logic       rst, req, irq;
  logic [2:0] op;
  logic       ready, mem_en, mem_read, mem_write, stack_push, stack_pop, done, err;
  logic [7:0] pc_in, wdata_in, wdata, mem_rdata, sp, rdata;
  logic [3:0] ccr_in, ccr_rd, stack_ctrl, ccr_out;
  int n_cmp = 0;
  int n_bad = 0;

  stack_op_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .ready(ready), .pc_in(pc_in),
    .ccr_in(ccr_in), .wdata_in(wdata_in), .irq(irq), .mem_en(mem_en),
    .mem_read(mem_read), .mem_write(mem_write), .stack_ctrl(stack_ctrl),
    .stack_push(stack_push), .stack_pop(stack_pop), .wdata(wdata),
    .mem_rdata(mem_rdata), .ccr_rd(ccr_rd), .sp(sp), .done(done),
    .rdata(rdata), .ccr_out(ccr_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request during IDLE and return at the BUS1 negedge.
  task automatic start_op(input logic [2:0] o, input logic [7:0] pc, input logic [3:0] cc,
                          input logic [7:0] wd, input logic [7:0] mrd, input logic [3:0] crd);
    @(negedge clk);
    req = 1'b1; op = o; pc_in = pc; ccr_in = cc; wdata_in = wd; mem_rdata = mrd; ccr_rd = crd;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; irq = 1'b0; op = 3'd0; pc_in = 8'h0; ccr_in = 4'h0;
    wdata_in = 8'h0; mem_rdata = 8'h0; ccr_rd = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_ready", ready, 1); chk("rst_sp", sp, 255); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_ctrl", stack_ctrl, 0); chk("rst_rdata", rdata, 0);

    // PUSH A5
    start_op(3'd0, 8'h00, 4'h0, 8'hA5, 8'h00, 4'h0);
    chk("push_ctrl", stack_ctrl, 1); chk("push_en", mem_en, 1); chk("push_wr", mem_write, 1);
    chk("push_rd", mem_read, 0); chk("push_sp_q", stack_push, 1); chk("push_wdata", wdata, 8'hA5);
    chk("push_ready", ready, 0); chk("push_sp_b1", sp, 255);
    @(negedge clk);
    chk("push_done", done, 1); chk("push_err", err, 0); chk("push_sp", sp, 254);
    chk("push_ctrl_d", stack_ctrl, 0); chk("push_en_d", mem_en, 0);

    // POP returns A5
    start_op(3'd1, 8'h00, 4'h0, 8'h00, 8'hA5, 4'h0);
    chk("pop_ctrl", stack_ctrl, 2); chk("pop_rd", mem_read, 1); chk("pop_wr", mem_write, 0);
    chk("pop_q", stack_pop, 1);
    @(negedge clk);
    chk("pop_done", done, 1); chk("pop_rdata", rdata, 8'hA5); chk("pop_sp", sp, 255);

    // INTR via op=5
    start_op(3'd5, 8'h10, 4'b1010, 8'h00, 8'h00, 4'h0);
    chk("intr1_ctrl", stack_ctrl, 6); chk("intr1_wdata", wdata, 8'h10);
    chk("intr1_push", stack_push, 1); chk("intr1_sp", sp, 255);
    @(negedge clk);
    chk("intr2_ctrl", stack_ctrl, 7); chk("intr2_wr", mem_write, 1); chk("intr2_push", stack_push, 0);
    chk("intr2_wdata", wdata, 8'h0A); chk("intr2_sp", sp, 254); chk("intr2_done", done, 0);
    @(negedge clk);
    chk("intr_done", done, 1); chk("intr_sp", sp, 254); chk("intr_ctrl_d", stack_ctrl, 0);

    // RTI
    start_op(3'd4, 8'h00, 4'h0, 8'h00, 8'h11, 4'hA);
    chk("rti_ctrl", stack_ctrl, 5); chk("rti_rd", mem_read, 1);
    @(negedge clk);
    chk("rti_rdata", rdata, 8'h11); chk("rti_ccr", ccr_out, 4'hA); chk("rti_sp", sp, 255);

    // CALL / RET
    start_op(3'd2, 8'h42, 4'h0, 8'h00, 8'h00, 4'h0);
    chk("call_ctrl", stack_ctrl, 3); chk("call_wdata", wdata, 8'h42);
    @(negedge clk);
    chk("call_sp", sp, 254);
    start_op(3'd3, 8'h00, 4'h0, 8'h00, 8'h43, 4'h5);
    chk("ret_ctrl", stack_ctrl, 4);
    @(negedge clk);
    chk("ret_rdata", rdata, 8'h43); chk("ret_sp", sp, 255); chk("ret_ccr_kept", ccr_out, 4'hA);

    // Underflow
    start_op(3'd1, 8'h00, 4'h0, 8'h00, 8'h77, 4'h0);
    chk("uf_en", mem_en, 0); chk("uf_rd", mem_read, 0); chk("uf_ctrl", stack_ctrl, 0);
    chk("uf_err_early", err, 0);
    @(negedge clk);
    chk("uf_err", err, 1); chk("uf_done", done, 1); chk("uf_rdata", rdata, 0); chk("uf_sp", sp, 255);

    // Illegal op
    start_op(3'd6, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0);
    chk("ill_en", mem_en, 0); chk("ill_ctrl", stack_ctrl, 0);
    @(negedge clk);
    chk("ill_err", err, 1); chk("ill_done", done, 1); chk("ill_sp", sp, 255);

    // req held high through the operation is not queued
    @(negedge clk);
    req = 1'b1; op = 3'd0; wdata_in = 8'h3C;
    @(negedge clk);
    chk("hold_b1_ctrl", stack_ctrl, 1);
    @(negedge clk);
    req = 1'b0;
    chk("hold_done", done, 1); chk("hold_sp", sp, 254);
    @(negedge clk);
    chk("hold_idle_ready", ready, 1); chk("hold_idle_ctrl", stack_ctrl, 0);
    @(negedge clk);
    chk("hold_no_queue_en", mem_en, 0); chk("hold_sp2", sp, 254);

`ifndef STACK_SEQ_IRQ_EN
    // irq ignored in the default build
    irq = 1'b1;
    chk("irq_ign_ready", ready, 1);
    @(negedge clk);
    chk("irq_ign_ctrl", stack_ctrl, 0); chk("irq_ign_en", mem_en, 0);
    @(negedge clk);
    chk("irq_ign_sp", sp, 254);
    irq = 1'b0;
`endif

    // Overflow: 56 pushes from reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("ov_rst_sp", sp, 255);
    for (int i = 0; i < 55; i++) begin
      start_op(3'd0, 8'h00, 4'h0, i[7:0], 8'h00, 4'h0);
      @(negedge clk);
    end
    chk("ov_sp55", sp, 200);
    start_op(3'd0, 8'h00, 4'h0, 8'hEE, 8'h00, 4'h0);
    chk("ov_wr", mem_write, 0); chk("ov_en", mem_en, 0);
    @(negedge clk);
    chk("ov_err", err, 1); chk("ov_done", done, 1); chk("ov_sp", sp, 200);
    start_op(3'd5, 8'h99, 4'h1, 8'h00, 8'h00, 4'h0);
    chk("ov_intr_en", mem_en, 0);
    @(negedge clk);
    chk("ov_intr_err", err, 1); chk("ov_intr_sp", sp, 200);

    // Reset mid-operation
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`ifdef STACK_SEQ_IRQ_EN
    @(negedge clk);
    irq = 1'b1; req = 1'b1; op = 3'd1; pc_in = 8'h20; ccr_in = 4'h3;
    chk("irq_ready0", ready, 0);
    @(negedge clk);
    irq = 1'b0; req = 1'b0;
    chk("irq_ctrl", stack_ctrl, 6); chk("irq_wdata", wdata, 8'h20);
`else
    start_op(3'd2, 8'h20, 4'h0, 8'h00, 8'h00, 4'h0);
    chk("mid_ctrl", stack_ctrl, 3);
`endif
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_ctrl_rst", stack_ctrl, 0); chk("mid_done", done, 0); chk("mid_sp", sp, 255);
    chk("mid_ready", ready, 1);
    @(negedge clk);
    chk("mid_no_bus2", stack_ctrl, 0); chk("mid_no_done", done, 0); chk("mid_sp2", sp, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
